bias_stream_bram: RTL

BIAS_STREAM_BRAM -- requirements
Module: bias_stream_bram

---
 rtl/bias_stream_bram.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bias_stream_bram.sv
// bias_stream_bram: row-wide bias memory with a credit-controlled read streamer.
//   clka/rstb          : clock, synchronous active-high reset
//   wr_en/wr_addr      : row write strobe and address (rows >= DEPTH ignored)
//   wr_lane_en/wr_data : per-lane write mask and row data (lane i at [i*DATA_W +: DATA_W])
//   start/base_addr/count : launch a stream of count beats from base_addr, wrapping at DEPTH
//   busy/done          : stream in progress / one-cycle completion pulse
//   m_valid/m_ready/m_data/m_last : output beat handshake, m_last on the final beat
module bias_stream_bram #(
    parameter int unsigned DATA_W    = 40,
    parameter int unsigned DEPTH     = 49,
    parameter int unsigned LANES     = 4,
    parameter int unsigned OUT_REG   = 1,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic                     clka,
    input  logic                     rstb,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [LANES-1:0]         wr_lane_en,
    input  logic [LANES*DATA_W-1:0]  wr_data,
    input  logic                     start,
    input  logic [AW-1:0]            base_addr,
    input  logic [CW-1:0]            count,
    output logic                     busy,
    output logic                     done,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [LANES*DATA_W-1:0]  m_data,
    output logic                     m_last
);

    localparam int unsigned ROW_W     = LANES * DATA_W;
    localparam int unsigned BW        = ROW_W + 1;
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    logic [ROW_W-1:0] mem [DEPTH];

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [CW-1:0]  remain_q, remain_d;
    logic           busy_q, done_q, done_d;

    logic           rd_en_c, rd_last_c;
    logic [AW-1:0]  rd_addr_c, base_mod;

    // RAM read pipeline: stage 1 is the array output register, stage 2 the optional extra register
    logic             s1_v, s1_l, s2_v, s2_l;
    logic [ROW_W-1:0] s1_d, s2_d;
    logic             in_v, in_l;
    logic [ROW_W-1:0] in_d;

    // Output buffer: one output register plus a 3-entry FIFO behind it (4 entries total)
    logic             ov, ol;
    logic [ROW_W-1:0] od;
    logic [BW-1:0]    fifo_mem [3];
    logic [1:0]       fifo_wp, fifo_rp, fifo_cnt;
    logic             pop, out_free, fifo_pop, in_direct, fifo_push, last_acc;
    logic [2:0]       occ;
    logic             credit_ok;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == LAST_ROW) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Memory image: all-zero; the array itself is never touched by reset
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    end

    // 2^AW < 2*DEPTH, so a single conditional subtract is an exact modulo
    always_comb begin
        base_mod = base_addr;
        if ({1'b0, base_addr} >= DEPTH_EXT) base_mod = AW'({1'b0, base_addr} - DEPTH_EXT);
    end

    // Masked row write and read-first array read
    always_ff @(posedge clka) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_EXT)) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_lane_en[i]) mem[wr_addr][i*DATA_W +: DATA_W] <= wr_data[i*DATA_W +: DATA_W];
            end
        end
        if (rd_en_c) s1_d <= mem[rd_addr_c];
    end

    always_comb begin
        in_v = (OUT_REG != 0) ? s2_v : s1_v;
        in_l = (OUT_REG != 0) ? s2_l : s1_l;
        in_d = (OUT_REG != 0) ? s2_d : s1_d;
    end

    // Buffer steering: FIFO head has priority over fresh RAM data to keep order
    always_comb begin
        pop       = ov & m_ready;
        out_free  = ~ov | pop;
        fifo_pop  = out_free & (fifo_cnt != 2'd0);
        in_direct = out_free & (fifo_cnt == 2'd0) & in_v;
        fifo_push = in_v & ~in_direct;
        last_acc  = pop & ol;
        // Occupancy ignores this cycle's pop, so a read never outruns free space
        occ       = 3'(ov) + 3'(fifo_cnt) + 3'(s1_v) + 3'(s2_v & (OUT_REG != 0));
        credit_ok = (occ < 3'd4);
    end

    // Next-state and read-issue logic; the first read goes out in the start cycle
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        rd_en_c   = 1'b0;
        rd_addr_c = addr_q;
        rd_last_c = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rd_en_c   = 1'b1;
                        rd_addr_c = base_mod;
                        rd_last_c = (count == CW'(1));
                        addr_d    = wrap_inc(base_mod);
                        remain_d  = count - CW'(1);
                        state_d   = (count == CW'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    rd_en_c   = 1'b1;
                    rd_last_c = (remain_q == CW'(1));
                    addr_d    = wrap_inc(addr_q);
                    remain_d  = remain_q - CW'(1);
                    if (remain_q == CW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_acc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, control and buffer registers
    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s1_v     <= 1'b0;
            s1_l     <= 1'b0;
            s2_v     <= 1'b0;
            s2_l     <= 1'b0;
            s2_d     <= '0;
            ov       <= 1'b0;
            ol       <= 1'b0;
            od       <= '0;
            fifo_wp  <= 2'd0;
            fifo_rp  <= 2'd0;
            fifo_cnt <= 2'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
            s1_v     <= rd_en_c;
            s1_l     <= rd_last_c;
            s2_v     <= s1_v & (OUT_REG != 0);
            s2_l     <= s1_l;
            s2_d     <= s1_d;
            if (out_free) begin
                if (fifo_pop) begin
                    {ol, od} <= fifo_mem[fifo_rp];
                    ov       <= 1'b1;
                end else if (in_v) begin
                    ol <= in_l;
                    od <= in_d;
                    ov <= 1'b1;
                end else begin
                    ov <= 1'b0;
                end
            end
            if (fifo_push) fifo_wp <= ptr_inc(fifo_wp);
            if (fifo_pop)  fifo_rp <= ptr_inc(fifo_rp);
            fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
        end
    end

    // FIFO storage needs no reset; fifo_cnt qualifies every read
    always_ff @(posedge clka) begin
        if (!rstb && fifo_push) fifo_mem[fifo_wp] <= {in_l, in_d};
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign m_valid = ov;
    assign m_data  = od;
    assign m_last  = ol;

endmodule
